// File: rtl/mul8_err_monitor_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mul8_err_monitor_if
// Purpose  : Sample bus carrying one operand pair plus the approximate
//            product from an 8x8 approximate multiplier into its monitor.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface mul8_err_monitor_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [15:0] in_prod;

  // Producer side: offers samples, observes ready
  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_prod,
    input  in_ready
  );

  // Monitor side: consumes samples, drives ready
  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_prod,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/mul8_err_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mul8_err_monitor
// Purpose  : Error characterisation of an 8x8 approximate multiplier. Over a
//            programmed number of samples it accumulates the absolute-error
//            sum, the worst-case error with its operands, and the count of
//            erroneous samples. Three-stage pipeline, one sample per cycle.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module mul8_err_monitor #(
  parameter int CNT_W = 17,  // sample target / counter width
  parameter int ACC_W = 33   // error-sum width, keep >= CNT_W+16 to avoid wrap
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  input  wire logic [CNT_W-1:0] n_samples,
  mul8_err_monitor_if.slave     s_bus,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_W-1:0]      err_sum,
  output logic [15:0]           err_max,
  output logic [7:0]            max_a,
  output logic [7:0]            max_b,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      smp_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Control state
  state_t           state_q,   state_d;
  logic [CNT_W-1:0] n_tgt_q,   n_tgt_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;

  // Pipeline stage 1: raw sample
  logic             s1_vld_q,  s1_vld_d;
  logic [7:0]       s1_a_q,    s1_a_d;
  logic [7:0]       s1_b_q,    s1_b_d;
  logic [15:0]      s1_prod_q, s1_prod_d;

  // Pipeline stage 2: absolute error with its operands
  logic             s2_vld_q,  s2_vld_d;
  logic [7:0]       s2_a_q,    s2_a_d;
  logic [7:0]       s2_b_q,    s2_b_d;
  logic [15:0]      s2_err_q,  s2_err_d;

  // Stage 3: accumulated statistics
  logic [ACC_W-1:0] err_sum_q, err_sum_d;
  logic [15:0]      err_max_q, err_max_d;
  logic [7:0]       max_a_q,   max_a_d;
  logic [7:0]       max_b_q,   max_b_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             in_ready;
  logic             accept;
  logic             clear_stats;
  logic [15:0]      exact;
  logic [15:0]      abs_err;

  assign in_ready       = (state_q == RUN);
  assign accept         = s_bus.in_valid & in_ready;
  assign s_bus.in_ready = in_ready;

  // FSM next state, run bookkeeping and sample counting
  always_comb begin
    state_d     = state_q;
    n_tgt_d     = n_tgt_q;
    smp_cnt_d   = smp_cnt_q;
    clear_stats = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          clear_stats = 1'b1;
          n_tgt_d     = n_samples;
          smp_cnt_d   = '0;
          // An empty run completes immediately with all-zero statistics
          state_d     = (n_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          smp_cnt_d = smp_cnt_q + CNT_W'(1);
          if (smp_cnt_q + CNT_W'(1) == n_tgt_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Stats are final once the last sample has left stage 2
        if (!s1_vld_q && !s2_vld_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Error pipeline: capture, absolute error, accumulate
  always_comb begin
    exact   = {8'd0, s1_a_q} * {8'd0, s1_b_q};
    abs_err = (exact >= s1_prod_q) ? (exact - s1_prod_q) : (s1_prod_q - exact);

    s1_vld_d  = accept;
    s1_a_d    = accept ? s_bus.in_a    : s1_a_q;
    s1_b_d    = accept ? s_bus.in_b    : s1_b_q;
    s1_prod_d = accept ? s_bus.in_prod : s1_prod_q;

    s2_vld_d  = s1_vld_q;
    s2_a_d    = s1_vld_q ? s1_a_q  : s2_a_q;
    s2_b_d    = s1_vld_q ? s1_b_q  : s2_b_q;
    s2_err_d  = s1_vld_q ? abs_err : s2_err_q;

    err_sum_d = err_sum_q;
    err_max_d = err_max_q;
    max_a_d   = max_a_q;
    max_b_d   = max_b_q;
    err_cnt_d = err_cnt_q;

    if (clear_stats) begin
      err_sum_d = '0;
      err_max_d = '0;
      max_a_d   = '0;
      max_b_d   = '0;
      err_cnt_d = '0;
    end else if (s2_vld_q) begin
      err_sum_d = err_sum_q + ACC_W'(s2_err_q);
      if (s2_err_q != 16'd0) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      // Strict compare so a tie keeps the earliest worst-case sample
      if (s2_err_q > err_max_q) begin
        err_max_d = s2_err_q;
        max_a_d   = s2_a_q;
        max_b_d   = s2_b_q;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      n_tgt_q   <= '0;
      smp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      n_tgt_q   <= n_tgt_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end

  // Pipeline and statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_prod_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_a_q    <= '0;
      s2_b_q    <= '0;
      s2_err_q  <= '0;
      err_sum_q <= '0;
      err_max_q <= '0;
      max_a_q   <= '0;
      max_b_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_prod_q <= s1_prod_d;
      s2_vld_q  <= s2_vld_d;
      s2_a_q    <= s2_a_d;
      s2_b_q    <= s2_b_d;
      s2_err_q  <= s2_err_d;
      err_sum_q <= err_sum_d;
      err_max_q <= err_max_d;
      max_a_q   <= max_a_d;
      max_b_q   <= max_b_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign busy    = (state_q == RUN) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign err_sum = err_sum_q;
  assign err_max = err_max_q;
  assign max_a   = max_a_q;
  assign max_b   = max_b_q;
  assign err_cnt = err_cnt_q;
  assign smp_cnt = smp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mul8_err_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_mul8_err_monitor
// Purpose  : Self-checking bench for mul8_err_monitor. Statistics are
//            recomputed from the list of accepted samples.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_mul8_err_monitor;
  localparam int CNT_W = 17;
  localparam int ACC_W = 33;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] n_samples;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] err_sum;
  logic [15:0]      err_max;
  logic [7:0]       max_a;
  logic [7:0]       max_b;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] smp_cnt;

  mul8_err_monitor_if bus ();

  mul8_err_monitor #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n_samples(n_samples),
    .s_bus    (bus.slave),
    .busy     (busy),
    .done     (done),
    .err_sum  (err_sum),
    .err_max  (err_max),
    .max_a    (max_a),
    .max_b    (max_b),
    .err_cnt  (err_cnt),
    .smp_cnt  (smp_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Samples waiting to be offered, and samples the monitor has taken
  int pa[$], pb[$], pp[$];
  int aa[$], ab[$], ap[$];
  int n_run;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int b, input int p);
    pa.push_back(a);
    pb.push_back(b);
    pp.push_back(p);
  endtask

  task automatic push_rand(input int k);
    for (int i = 0; i < k; i++) begin
      int a, b, ex, p;
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      ex = a * b;
      case ($urandom_range(0, 3))
        0:       p = ex;
        1:       p = ex + int'($urandom_range(0, 300));
        2:       p = ex - int'($urandom_range(0, 300));
        default: p = int'($urandom_range(0, 65535));
      endcase
      if (p < 0)     p = 0;
      if (p > 65535) p = 65535;
      push(a, b, p);
    end
  endtask

  task automatic drive_junk();
    bus.in_a    = 8'($urandom);
    bus.in_b    = 8'($urandom);
    bus.in_prod = 16'($urandom);
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    n_samples = CNT_W'(n);
    tick();
    start     = 1'b0;
    n_samples = CNT_W'($urandom);
    n_run     = n;
    aa.delete(); ab.delete(); ap.delete();
    check("start_busy",    busy,    (n != 0));
    check("start_done",    done,    (n == 0));
    check("start_smp_cnt", smp_cnt, 0);
    check("start_err_sum", err_sum, 0);
    check("start_ready",   bus.in_ready, (n != 0));
  endtask

  // Recompute every statistic from the accepted-sample list
  task automatic check_stats();
    longint sum = 0;
    int mx = 0, ma = 0, mb = 0, cnt = 0;
    for (int i = 0; i < aa.size(); i++) begin
      int e;
      e = aa[i] * ab[i] - ap[i];
      if (e < 0) e = -e;
      sum += e;
      if (e != 0) cnt++;
      if (e > mx) begin
        mx = e; ma = aa[i]; mb = ab[i];
      end
    end
    check("err_sum", err_sum, sum);
    check("err_max", err_max, mx);
    check("max_a",   max_a,   ma);
    check("max_b",   max_b,   mb);
    check("err_cnt", err_cnt, cnt);
    check("smp_cnt", smp_cnt, aa.size());
  endtask

  // mode 0: always valid, 1: valid on even cycles, 2: random gaps
  task automatic feed(input int mode, input int stop_after, input bit poke_start);
    int cyc = 0;
    bit v;
    while (aa.size() < n_run && aa.size() < stop_after && cyc < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (v && pa.size() == 0) push_rand(1);
      bus.in_valid = v;
      if (v) begin
        bus.in_a    = 8'(pa[0]);
        bus.in_b    = 8'(pb[0]);
        bus.in_prod = 16'(pp[0]);
      end else begin
        drive_junk();
      end
      if (poke_start && cyc == 2) begin
        start     = 1'b1;
        n_samples = CNT_W'(1);
      end else begin
        start = 1'b0;
      end
      check("run_ready", bus.in_ready, 1);
      tick();
      if (v) begin
        aa.push_back(pa.pop_front());
        ab.push_back(pb.pop_front());
        ap.push_back(pp.pop_front());
        check("run_smp_cnt", smp_cnt, aa.size());
      end
      cyc++;
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;
    if (cyc >= 1000) begin
      checks++;
      errors++;
      $error("FAIL feed_timeout: observed=%0d accepts expected=%0d", aa.size(), n_run);
    end
  endtask

  // Called right after the edge of the final accept
  task automatic finish_run();
    bus.in_valid = 1'b1;
    drive_junk();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check("drain_ready", bus.in_ready, 0);
      check("drain_done",  done, (i == 3));
      check("drain_busy",  busy, (i < 3));
    end
    check_stats();
    tick();
    tick();
    check("hold_done", done, 1);
    check_stats();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    n_samples    = '0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_prod  = '0;
    n_run        = 0;

    // Reset state
    #2;
    check("rst_ready_async", bus.in_ready, 0);
    tick();
    tick();
    check("rst_ready",   bus.in_ready, 0);
    check("rst_busy",    busy,    0);
    check("rst_done",    done,    0);
    check("rst_err_sum", err_sum, 0);
    check("rst_err_max", err_max, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_smp_cnt", smp_cnt, 0);
    rst = 1'b0;
    tick();

    // Directed: single erroneous sample among exact ones, back-to-back
    push(10, 10, 100); push(255, 255, 65025); push(3, 5, 16);
    do_start(3);
    feed(0, 1 << 20, 1'b0);
    finish_run();
    check("t1_err_sum", err_sum, 1);
    check("t1_err_max", err_max, 1);
    check("t1_max_a",   max_a,   3);
    check("t1_max_b",   max_b,   5);
    check("t1_err_cnt", err_cnt, 1);
    check("t1_smp_cnt", smp_cnt, 3);

    // Directed: equal worst-case errors, the first one is kept
    push(200, 200, 39732); push(200, 200, 40268);
    do_start(2);
    feed(2, 1 << 20, 1'b0);
    finish_run();
    check("t2_err_max", err_max, 268);
    check("t2_max_a",   max_a,   200);
    check("t2_err_sum", err_sum, 536);
    check("t2_err_cnt", err_cnt, 2);

    // Alternating valid, extra offers after the last one ignored
    push_rand(4);
    do_start(4);
    feed(1, 1 << 20, 1'b0);
    finish_run();
    check("t3_smp_cnt", smp_cnt, 4);

    // start pulsed mid-run must be ignored
    push_rand(6);
    do_start(6);
    feed(0, 1 << 20, 1'b1);
    finish_run();

    // Empty run
    do_start(0);
    check_stats();
    tick();
    check("n0_done_hold", done, 1);

    // Random runs with random gaps
    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, 40));
      pa.delete(); pb.delete(); pp.delete();
      push_rand(n);
      do_start(n);
      feed(2, 1 << 20, 1'b0);
      finish_run();
    end

    // Reset mid-run aborts everything
    pa.delete(); pb.delete(); pp.delete();
    push_rand(5);
    do_start(5);
    feed(0, 2, 1'b0);
    tick();
    #3;
    rst = 1'b1;
    #1;
    check("abort_ready",   bus.in_ready, 0);
    check("abort_busy",    busy,    0);
    check("abort_done",    done,    0);
    check("abort_smp_cnt", smp_cnt, 0);
    check("abort_err_sum", err_sum, 0);
    check("abort_err_cnt", err_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    check("abort_idle_busy", busy, 0);
    check("abort_idle_done", done, 0);
    pa.delete(); pb.delete(); pp.delete();
    push(0, 0, 1);
    do_start(1);
    feed(0, 1 << 20, 1'b0);
    finish_run();
    check("t7_err_sum", err_sum, 1);
    check("t7_err_max", err_max, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
